// File: rtl/fixed_point_dot.sv
// Fixed-point dot product: accumulates a*b terms until in_last or MAX_TERMS; result held for the consumer.
// Latency: result valid the cycle after the final accepted beat.
// Backpressure: in_ready drops while a result is held; out_ready low holds all outputs stable.
`ifndef FIXED_W
`define FIXED_W 32
`endif
`ifndef FIXED_FRACTION_W
`define FIXED_FRACTION_W 16
`endif

package fixed_point_pkg;
    typedef logic signed [`FIXED_W-1:0] fixed_point_t;

    // Full-width signed product rescaled to Q format; ovf when the rescaled value does not fit FIXED_W.
    function automatic fixed_point_t fixed_mul(input fixed_point_t a, input fixed_point_t b,
                                               output logic ovf);
        logic signed [2*`FIXED_W-1:0] full;
        logic signed [2*`FIXED_W-1:0] shifted;
        fixed_point_t                 trunc;
        full    = a * b;
        shifted = full >>> `FIXED_FRACTION_W;
        trunc   = shifted[`FIXED_W-1:0];
        ovf     = (shifted != {{`FIXED_W{trunc[`FIXED_W-1]}}, trunc});
        return trunc;
    endfunction
endpackage

module fixed_point_dot
    import fixed_point_pkg::*;
#(
    parameter int MAX_TERMS = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  fixed_point_t                   in_a,
    input  fixed_point_t                   in_b,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output fixed_point_t                   result,
    output logic                           overflow,
    output logic                           length_error,
    output logic [$clog2(MAX_TERMS+1)-1:0] term_count
);
    localparam int CW = $clog2(MAX_TERMS+1);
    localparam int W  = `FIXED_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    fixed_point_t  acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;

    // Held copy of the last completed vector; the running accumulator may diverge while a new vector builds.
    fixed_point_t  result_q, result_d;
    logic [CW-1:0] term_count_q, term_count_d;
    logic          overflow_q, overflow_d;
    logic          length_error_q, length_error_d;

    fixed_point_t  prod;
    logic          prod_ovf;
    fixed_point_t  sum;
    logic          add_ovf;
    fixed_point_t  beat_val;
    logic [CW-1:0] beat_cnt;
    logic          beat_ovf;
    logic          accept;

    assign in_ready     = (state_q != DONE);
    assign out_valid    = (state_q == DONE);
    assign accept       = in_valid && in_ready;
    assign result       = result_q;
    assign overflow     = overflow_q;
    assign length_error = length_error_q;
    assign term_count   = term_count_q;

    always_comb begin
        prod_ovf = 1'b0;
        prod     = fixed_mul(in_a, in_b, prod_ovf);
        sum      = acc_q + prod;
        add_ovf  = (acc_q[W-1] == prod[W-1]) && (sum[W-1] != acc_q[W-1]);

        // The first term of a vector loads rather than adds, so it has no add overflow.
        if (state_q == IDLE) begin
            beat_val = prod;
            beat_cnt = CW'(1);
            beat_ovf = prod_ovf;
        end else begin
            beat_val = sum;
            beat_cnt = cnt_q + CW'(1);
            beat_ovf = ovf_q | prod_ovf | add_ovf;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        result_d       = result_q;
        term_count_d   = term_count_q;
        overflow_d     = overflow_q;
        length_error_d = length_error_q;

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    acc_d = beat_val;
                    cnt_d = beat_cnt;
                    ovf_d = beat_ovf;
                    if (in_last || (beat_cnt == CW'(MAX_TERMS))) begin
                        state_d        = DONE;
                        result_d       = beat_val;
                        term_count_d   = beat_cnt;
                        overflow_d     = beat_ovf;
                        length_error_d = !in_last;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            cnt_q          <= '0;
            ovf_q          <= 1'b0;
            result_q       <= '0;
            term_count_q   <= '0;
            overflow_q     <= 1'b0;
            length_error_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            ovf_q          <= ovf_d;
            result_q       <= result_d;
            term_count_q   <= term_count_d;
            overflow_q     <= overflow_d;
            length_error_q <= length_error_d;
        end
    end
endmodule

// File: tb/tb_fixed_point_dot.sv
// Scoreboarded bench for fixed_point_dot with MAX_TERMS=4, Q16.16 operands.
module tb_fixed_point_dot;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        length_error;
    logic [2:0]  term_count;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  cnt;
        logic        ovf;
        logic        le;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fixed_point_dot #(.MAX_TERMS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .overflow     (overflow),
        .length_error (length_error),
        .term_count   (term_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic push(input logic [31:0] res, input logic [2:0] cnt, input logic ovf, input logic le);
        exp_t e;
        e.res = res;
        e.cnt = cnt;
        e.ovf = ovf;
        e.le  = le;
        exp_q.push_back(e);
    endtask

    // Caller is positioned just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: got in_ready=0 for 50 cycles expected 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got result %h expected no output", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_result", result, e.res);
                chk("sb_term_count", 32'(term_count), 32'(e.cnt));
                chk("sb_overflow", 32'(overflow), 32'(e.ovf));
                chk("sb_length_error", 32'(length_error), 32'(e.le));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_term_count", 32'(term_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_length_error", 32'(length_error), 32'd0);
        @(posedge clk); #1;

        // 1*2 + 3*4 + (-1)*0.5 = 13.5
        push(32'h000D_8000, 3'd3, 1'b0, 1'b0);
        send_beat(32'h0001_0000, 32'h0002_0000, 1'b0);
        send_beat(32'h0003_0000, 32'h0004_0000, 1'b0);
        @(negedge clk);
        chk("t1_not_early", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        send_beat(32'hFFFF_0000, 32'h0000_8000, 1'b1);
        @(negedge clk);
        chk("t1_latency", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_back_idle_ready", 32'(in_ready), 32'd1);
        chk("t1_back_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Four terms without last hits MAX_TERMS; a fifth beat must be refused.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
        in_valid = 1'b1;
        in_a     = 32'h0001_0000;
        in_b     = 32'h0001_0000;
        in_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t2_out_valid", 32'(out_valid), 32'd1);
            chk("t2_in_ready", 32'(in_ready), 32'd0);
            chk("t2_result", result, 32'h0004_0000);
            chk("t2_length_error", 32'(length_error), 32'd1);
        end
        @(posedge clk); #1;
        push(32'h0004_0000, 3'd4, 1'b0, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;

        // Wrapping partial sum
        push(32'hFFFE_0000, 3'd2, 1'b1, 1'b0);
        send_beat(32'h7FFF_0000, 32'h0001_0000, 1'b0);
        send_beat(32'h7FFF_0000, 32'h0001_0000, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;

        // last on the MAX_TERMS-th beat is not a length error
        push(32'h0001_0000, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(32'h0000_8000, 32'h0000_8000, (i == 3) ? 1'b1 : 1'b0);
        @(negedge clk);
        @(posedge clk); #1;

        // Stalled consumer with a pending beat on the input
        out_ready = 1'b0;
        push(32'h0006_0000, 3'd1, 1'b0, 1'b0);
        send_beat(32'h0002_0000, 32'h0003_0000, 1'b1);
        push(32'h0001_0000, 3'd1, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_a     = 32'h0001_0000;
        in_b     = 32'h0001_0000;
        in_last  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t5_hold_valid", 32'(out_valid), 32'd1);
            chk("t5_hold_ready", 32'(in_ready), 32'd0);
            chk("t5_hold_result", result, 32'h0006_0000);
            chk("t5_hold_count", 32'(term_count), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_ready_after", 32'(in_ready), 32'd1);
        chk("t5_valid_after", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_second_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Reset discards a partial vector
        send_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
        send_beat(32'h0001_0000, 32'h0001_0000, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_result", result, 32'd0);
        chk("t6_rst_count", 32'(term_count), 32'd0);
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        push(32'h0004_0000, 3'd1, 1'b0, 1'b0);
        send_beat(32'h0002_0000, 32'h0002_0000, 1'b1);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
